// File: rtl/mp_add_seq_if.sv
// mp_add_seq_if: start/done request bus between a controller and the multi-precision adder
interface mp_add_seq_if #(parameter int NBYTES = 4);
    localparam int W = 8 * NBYTES;
    logic         start;
    logic         sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;
    logic         ovf;
    modport master (output start, sub, A, B, Cin, input busy, done, S, Cout, ovf);
    modport slave  (input start, sub, A, B, Cin, output busy, done, S, Cout, ovf);
endinterface

// File: rtl/mp_add_seq.sv
// mp_add_seq: byte-serial wide add/subtract built around a single 8-bit adder
module mp_add_seq #(
    parameter int NBYTES = 4
) (
    input logic        clk,
    input logic        rst,
    mp_add_seq_if.slave bus
);
    localparam int W = 8 * NBYTES;
    localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  s_reg;
    logic [IW-1:0] idx;
    logic          cy;
    logic          busy;
    logic          done;
    logic          cout;
    logic          ovf;
    logic [7:0]    a_byte;
    logic [7:0]    b_byte;
    logic [7:0]    sum;
    logic          carry;

    // the shared 8-bit adder, fed by the byte selected by idx and the held carry
    always_comb begin
        a_byte       = a_reg[8*idx +: 8];
        b_byte       = b_reg[8*idx +: 8];
        {carry, sum} = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, cy};
    end

    // sequencer: capture on start (B pre-inverted for subtract), then one byte per clock LSB first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
            idx   <= '0;
            cy    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    s_reg[8*idx +: 8] <= sum;
                    cy                <= carry;
                    idx               <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout  <= carry;
                        ovf   <= (a_byte[7] == b_byte[7]) & (sum[7] != a_byte[7]);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        a_reg <= bus.A;
                        b_reg <= bus.sub ? ~bus.B : bus.B;
                        cy    <= bus.sub | bus.Cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.S    = s_reg;
    assign bus.Cout = cout;
    assign bus.ovf  = ovf;
endmodule
